// File: rtl/wb_stage.sv
// Writeback pipeline register and retire logic for the pipelined Y86-64 core.
// Gates register-file writes on status, tracks halt, and counts retired instructions.
module wb_stage #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [WORD_W-1:0] m_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [3:0]        W_icode,
  output logic [2:0]        W_stat,
  output logic [3:0]        w_dstE,
  output logic [WORD_W-1:0] w_valE,
  output logic [3:0]        w_dstM,
  output logic [WORD_W-1:0] w_valM,
  output logic [2:0]        Stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          icode_q, icode_d;
  logic [2:0]          stat_q, stat_d;
  logic [3:0]          dst_e_q, dst_e_d;
  logic [3:0]          dst_m_q, dst_m_d;
  logic [WORD_W-1:0]   val_e_q, val_e_d;
  logic [WORD_W-1:0]   val_m_q, val_m_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic                excepting;
  logic                retire_now;

  // Anything other than bubble/AOK in W stops the machine.
  assign excepting  = (stat_q != STAT_BUB) && (stat_q != STAT_AOK);
  assign retire_now = ((stat_q == STAT_AOK) && !W_stall) || (stat_q == STAT_HLT);

  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    stat_d    = stat_q;
    dst_e_d   = dst_e_q;
    dst_m_d   = dst_m_q;
    val_e_d   = val_e_q;
    val_m_d   = val_m_q;
    retired_d = retired_q;

    if (state_q == ST_RUN) begin
      // The excepting instruction freezes W on the edge it enters HALTED.
      if (excepting) begin
        state_d = ST_HALTED;
      end else if (!W_stall) begin
        if (W_bubble) begin
          icode_d = ICODE_NOP;
          stat_d  = STAT_BUB;
          dst_e_d = RNONE;
          dst_m_d = RNONE;
          val_e_d = '0;
          val_m_d = '0;
        end else begin
          icode_d = m_icode;
          stat_d  = m_stat;
          dst_e_d = M_dstE;
          dst_m_d = M_dstM;
          val_e_d = m_valE;
          val_m_d = m_valM;
        end
      end

      if (retire_now && (retired_q != {CNT_W{1'b1}})) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      icode_q   <= ICODE_NOP;
      stat_q    <= STAT_BUB;
      dst_e_q   <= RNONE;
      dst_m_q   <= RNONE;
      val_e_q   <= '0;
      val_m_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      stat_q    <= stat_d;
      dst_e_q   <= dst_e_d;
      dst_m_q   <= dst_m_d;
      val_e_q   <= val_e_d;
      val_m_q   <= val_m_d;
      retired_q <= retired_d;
    end
  end

  assign W_icode = icode_q;
  assign W_stat  = stat_q;
  assign w_dstE  = (stat_q == STAT_AOK) ? dst_e_q : RNONE;
  assign w_dstM  = (stat_q == STAT_AOK) ? dst_m_q : RNONE;
  assign w_valE  = val_e_q;
  assign w_valM  = val_m_q;
  assign Stat    = (stat_q == STAT_BUB) ? STAT_AOK : stat_q;
  assign halted  = (state_q == ST_HALTED);
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load, stall, bubble, dual write, halt, reset, saturation.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  M_dstE, M_dstM;
  logic        W_stall, W_bubble;

  logic [3:0]  W_icode, w_dstE, w_dstM;
  logic [2:0]  W_stat, Stat;
  logic [63:0] w_valE, w_valM;
  logic        halted;
  logic [31:0] retired;

  logic [3:0]  s_W_icode, s_w_dstE, s_w_dstM;
  logic [2:0]  s_W_stat, s_Stat;
  logic [63:0] s_w_valE, s_w_valM;
  logic        s_halted;
  logic [2:0]  s_retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage #(.WORD_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble), .W_icode(W_icode), .W_stat(W_stat),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .Stat(Stat), .halted(halted), .retired(retired)
  );

  // Narrow counter copy sharing the same stimulus, used for the saturation case.
  wb_stage #(.WORD_W(64), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble), .W_icode(s_W_icode), .W_stat(s_W_stat),
    .w_dstE(s_w_dstE), .w_valE(s_w_valE), .w_dstM(s_w_dstM), .w_valM(s_w_valM),
    .Stat(s_Stat), .halted(s_halted), .retired(s_retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    m_stat  = st;
    m_icode = ic;
    M_dstE  = de;
    m_valE  = ve;
    M_dstM  = dm;
    m_valM  = vm;
  endtask

  initial begin
    reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    drive(3'd1, 4'h6, 4'h9, 64'hDEAD, 4'h9, 64'hBEEF);
    step(); step();
    check("rst_icode", 64'(W_icode), 64'h1);
    check("rst_wstat", 64'(W_stat), 64'h0);
    check("rst_dstE", 64'(w_dstE), 64'hF);
    check("rst_dstM", 64'(w_dstM), 64'hF);
    check("rst_valE", w_valE, 64'h0);
    check("rst_stat", 64'(Stat), 64'h1);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_retired", 64'(retired), 64'h0);

    // Basic AOK load
    reset = 1'b0;
    drive(3'd1, 4'h6, 4'h2, 64'h5, 4'hF, 64'h0);
    step();
    check("ld_dstE", 64'(w_dstE), 64'h2);
    check("ld_valE", w_valE, 64'h5);
    check("ld_dstM", 64'(w_dstM), 64'hF);
    check("ld_stat", 64'(Stat), 64'h1);
    check("ld_ret0", 64'(retired), 64'h0);
    drive(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    check("ld_ret1", 64'(retired), 64'h1);
    check("ld_bub_dstE", 64'(w_dstE), 64'hF);

    // Stall holds an irmovq for 4 cycles, counted once on release
    drive(3'd1, 4'h3, 4'h3, 64'h6, 4'hF, 64'h0);
    step();
    check("st_dstE_0", 64'(w_dstE), 64'h3);
    W_stall = 1'b1;
    drive(3'd1, 4'h6, 4'h7, 64'd99, 4'hF, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_dstE_h", 64'(w_dstE), 64'h3);
      check("st_valE_h", w_valE, 64'h6);
      check("st_ret_h", 64'(retired), 64'h1);
    end
    W_stall = 1'b0;
    drive(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    check("st_ret_rel", 64'(retired), 64'h2);
    check("st_dstE_rel", 64'(w_dstE), 64'hF);

    // Bubble insertion, then stall+bubble holds
    drive(3'd1, 4'h6, 4'h5, 64'h7, 4'hF, 64'h0);
    step();
    W_bubble = 1'b1;
    step();
    check("bb_wstat", 64'(W_stat), 64'h0);
    check("bb_icode", 64'(W_icode), 64'h1);
    check("bb_dstE", 64'(w_dstE), 64'hF);
    check("bb_dstM", 64'(w_dstM), 64'hF);
    check("bb_stat", 64'(Stat), 64'h1);
    check("bb_ret", 64'(retired), 64'h3);
    step();
    check("bb_ret2", 64'(retired), 64'h3);
    W_bubble = 1'b0;
    drive(3'd1, 4'h2, 4'h8, 64'h20, 4'hF, 64'h0);
    step();
    W_stall = 1'b1; W_bubble = 1'b1;
    step();
    check("sb_dstE", 64'(w_dstE), 64'h8);
    check("sb_wstat", 64'(W_stat), 64'h1);
    check("sb_icode", 64'(W_icode), 64'h2);
    check("sb_ret", 64'(retired), 64'h3);
    W_stall = 1'b0;
    step();
    check("sb_rel_wstat", 64'(W_stat), 64'h0);
    check("sb_rel_ret", 64'(retired), 64'h4);
    W_bubble = 1'b0;

    // popq-style dual write
    drive(3'd1, 4'hB, 4'h4, 64'h108, 4'h4, 64'h55);
    step();
    check("pq_dstE", 64'(w_dstE), 64'h4);
    check("pq_dstM", 64'(w_dstM), 64'h4);
    check("pq_valE", w_valE, 64'h108);
    check("pq_valM", w_valM, 64'h55);
    drive(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    check("pq_ret", 64'(retired), 64'h5);

    // ADR exception halts and freezes W
    drive(3'd3, 4'h5, 4'h2, 64'h1, 4'hF, 64'h0);
    step();
    check("adr_wstat", 64'(W_stat), 64'h3);
    check("adr_dstE", 64'(w_dstE), 64'hF);
    check("adr_stat", 64'(Stat), 64'h3);
    check("adr_halt0", 64'(halted), 64'h0);
    drive(3'd1, 4'h6, 4'h6, 64'h77, 4'hF, 64'h0);
    step();
    check("adr_halt1", 64'(halted), 64'h1);
    check("adr_frz_stat", 64'(W_stat), 64'h3);
    check("adr_frz_valE", w_valE, 64'h1);
    check("adr_ret", 64'(retired), 64'h5);
    step();
    check("adr_frz_dstE", 64'(w_dstE), 64'hF);
    check("adr_ret2", 64'(retired), 64'h5);

    // Reset while halted
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rh_halted", 64'(halted), 64'h0);
    check("rh_stat", 64'(Stat), 64'h1);
    check("rh_ret", 64'(retired), 64'h0);
    check("rh_dstE", 64'(w_dstE), 64'hF);

    // HLT retires once and halts
    drive(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    check("hlt_stat", 64'(Stat), 64'h2);
    check("hlt_halt0", 64'(halted), 64'h0);
    check("hlt_ret0", 64'(retired), 64'h0);
    drive(3'd1, 4'h6, 4'h1, 64'h3, 4'hF, 64'h0);
    step();
    check("hlt_halt1", 64'(halted), 64'h1);
    check("hlt_ret1", 64'(retired), 64'h1);
    step();
    check("hlt_ret_frz", 64'(retired), 64'h1);
    check("hlt_stat_frz", 64'(Stat), 64'h2);

    // Saturation on the narrow counter copy
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(3'd1, 4'h6, 4'h1, 64'(i), 4'hF, 64'h0);
      step();
    end
    drive(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    check("sat_wide", 64'(retired), 64'd9);
    check("sat_narrow", 64'(s_retired), 64'h7);
    step();
    check("sat_narrow_hold", 64'(s_retired), 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback (W) pipeline register and retire logic for the pipelined Y86-64 core; the write-side counterpart of the register file's srcA/srcB read path.
- Captures the memory-stage result, drives the register file's dstE/valE/dstM/valM write ports, and suppresses writes for excepting instructions.
- Produces the processor status and a halt state machine, and counts retired instructions.

Parameters:
WORD_W, 64, data width of valE/valM
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
m_stat  input  3  memory-stage status: 0=BUB, 1=AOK, 2=HLT, 3=ADR, 4=INS
m_icode  input  4  memory-stage icode (0=halt, 1=nop)
m_valE  input  WORD_W  ALU result from memory stage
m_valM  input  WORD_W  memory read data from memory stage
M_dstE  input  4  destination for valE (4'hF = RNONE)
M_dstM  input  4  destination for valM (4'hF = RNONE)
W_stall  input  1  hold W register
W_bubble  input  1  load bubble into W register
W_icode  output  4  registered icode
W_stat  output  3  registered status
w_dstE  output  4  register-file write address E (RNONE = no write)
w_valE  output  WORD_W  register-file write data E
w_dstM  output  4  register-file write address M (RNONE = no write)
w_valM  output  WORD_W  register-file write data M
Stat  output  3  processor status
halted  output  1  high in HALTED state
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, highest priority): W loads bubble. W_icode=1, W_stat=0 (BUB), W_dstE=W_dstM=4'hF, W_valE=W_valM=0. FSM=RUN, halted=0, retired=0.
- W register update priority at each edge: reset > FSM HALTED (hold) > W_stall (hold) > W_bubble (load bubble) > load m_*/M_* inputs. W_stall and W_bubble both high: stall wins.
- Latency: inputs appear on W outputs one cycle after the capturing edge. w_* outputs are combinational from the W register; no further delay.
- Write gating: w_dstE = (W_stat==AOK) ? W_dstE : 4'hF, and likewise w_dstM.
  - w_valE and w_valM always mirror the register.
  - BUB, HLT, ADR and INS never write.
  - If W_dstE == W_dstM != RNONE, both are driven. The register file gives the M port priority (popq %rsp semantics); no special handling here.
- Stat = (W_stat==BUB) ? AOK : W_stat. Values 5-7 are treated as INS for the halt decision and passed through unchanged on Stat.
- Halt FSM, states RUN and HALTED:
  - RUN -> HALTED at an edge where W_stat is in {HLT, ADR, INS} (anything other than BUB/AOK), regardless of W_stall.
  - HALTED is left only by reset.
  - While HALTED, the W register is frozen, so the excepting status stays visible on Stat and W_stat.
  - halted is registered: it rises one cycle after the excepting instruction reaches W.
- Retired counter:
  - Increments by 1 at an edge in RUN where either (W_stat==AOK and W_stall==0) or (W_stat==HLT).
  - A stalled instruction is counted once, on its departing edge.
  - Bubbles, ADR and INS are not counted.
  - Saturates at all-ones; no wrap.
  - No increments in HALTED.
- Reset mid-operation: any state, including HALTED, returns to reset values at that edge. Inputs present during the reset edge are discarded.

Test Plan:
- Reset then load m_stat=1, m_icode=6, M_dstE=2, m_valE=5, M_dstM=F -> next cycle w_dstE=2, w_valE=5, w_dstM=F, Stat=1, retired=1 after the following edge.
- W_stall=1 for 3 cycles holding an AOK irmovq (dstE=3, valE=6) -> w_dstE=3 for all 4 cycles; retired increments exactly once, on release.
- W_bubble=1 -> W_stat=0, W_icode=1, w_dstE=w_dstM=F, Stat=1 (AOK), retired unchanged. Then assert W_stall and W_bubble together -> register held.
- popq-style load: M_dstE=4, m_valE=0x108, M_dstM=4, m_valM=0x55 -> both ports show dst 4 on the same cycle.
- m_stat=3 (ADR) with M_dstE=2 -> w_dstE=F, Stat=3; halted=1 one cycle later; later m_* changes ignored and retired frozen. Same with m_stat=2 (HLT) -> retired +1.
- Assert reset while halted -> next cycle halted=0, Stat=1, retired=0, w_dstE=F. Separately, force retired to all-ones and retire one more -> stays all-ones.
